pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the MIPS-style core. It replaces the plain PC register and load-enable path.
- Computes next PC internally from a select code: sequential, branch, jump, or register.
- Adds a halt/resume state machine, misaligned-target trapping with a captured exception PC, and an optional return-address stack.
- Sits at the front of the fetch path and drives instruction-memory address and the link value.

Parameters:
- WIDTH, 32: PC/address width in bits; must be ≥ 32.
- RESET_VEC, 32'h0040_0000: PC value loaded on reset.
- TRAP_VEC, 32'h0040_0180: PC value loaded on a misaligned target.
- INC, 4: sequential increment.
- RAS_DEPTH, 4: return-address stack entries (power of two); used only with PC_RAS_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  advance/update when 1; everything holds when 0 (stall)
- pcsel  in  2  00 seq, 01 branch, 10 jump, 11 register
- br_offset  in  WIDTH  sign-extended word offset for branches
- jaddr  in  26  jump index field
- jr_target  in  WIDTH  register target
- halt  in  1  request halt
- resume  in  1  leave HALTED
- ras_push  in  1  push pc_plus (call); ignored without PC_RAS_EN
- ras_pop  in  1  with pcsel=11, take target from stack; ignored without PC_RAS_EN
- pc  out  WIDTH  current PC
- pc_plus  out  WIDTH  pc + INC, combinational (link value)
- running  out  1  1 in RUN state
- misalign_err  out  1  sticky trap flag
- epc  out  WIDTH  offending target captured on trap

Behaviour:
- Reset (reset=0 at a clock edge) has priority over everything:
  - pc=RESET_VEC, state=RUN, running=1, misalign_err=0, epc=0.
  - RAS is emptied.
- Next-PC candidate (combinational), all arithmetic modulo 2^WIDTH, wrap-around silent:
  - seq: pc_plus.
  - branch: pc_plus + (br_offset << 2).
  - jump: {pc_plus[WIDTH-1:28], jaddr, 2'b00}.
  - register: jr_target.
- State machine, RUN / HALTED, evaluated only when enable=1:
  - RUN, candidate[1:0] != 0: trap. pc<=TRAP_VEC, epc<=candidate, misalign_err<=1, stay RUN. Trap has priority over halt in the same cycle.
  - RUN, halt=1, no trap: pc<=candidate (the halting instruction completes), state<=HALTED.
  - RUN, otherwise: pc<=candidate.
  - HALTED: pc holds; resume=1 → RUN with no PC change. halt and resume both 1 in HALTED → stay HALTED.
- enable=0: pc, state, epc, misalign_err and RAS all hold, regardless of halt/resume/push/pop.
- misalign_err clears only on reset; a later trap overwrites epc.
- Latency: a new pc is visible one cycle after the enabling edge. pc_plus and running follow pc/state combinationally.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: RAS_DEPTH-entry circular stack, updated only when enable=1 in RUN.
  - ras_push pushes pc_plus.
  - pcsel=11 with ras_pop pops and uses the top entry as the target instead of jr_target.
  - Push when full overwrites the oldest entry (count saturates).
  - Pop when empty falls back to jr_target; count stays 0.
  - Simultaneous push and pop: the pop target is the old top, then pc_plus replaces it; count unchanged.
  - A trapping cycle does not modify the RAS.
- Undefined: no stack storage; ras_push/ras_pop are ignored; pcsel=11 always uses jr_target.

Decomposition:
- Package pc_pkg holds the pcsel_t enum (PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG), the state_t enum (RUN, HALTED), and default RESET_VEC/TRAP_VEC constants.
- One natural sub-module: pc_ras (stack storage, pointer, count), instantiated only under PC_RAS_EN.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with enable=1, pcsel=00 → pc reads 0x00400000, 0x00400004, 0x00400008 on successive cycles; running=1.
- Branch/jump at pc=0x00400010:
  - br_offset=-2 → 0x0040000C.
  - Then pcsel=10, jaddr=0x0100040 → 0x00400100.
  - Stall with enable=0 for 3 cycles → pc constant.
- Trap: pcsel=11, jr_target=0x00400102 → pc=0x00400180, epc=0x00400102, misalign_err=1. halt=1 in the same cycle → state stays RUN.
- Halt/resume: halt=1 at pc=0x00400020, seq → pc=0x00400024, running=0. Pc holds 5 cycles; resume=1 → running=1, next pc=0x00400028.
- Mid-operation reset: assert reset=0 while HALTED with misalign_err=1 → next edge pc=0x00400000, running=1, misalign_err=0.
- PC_RAS_EN, RAS_DEPTH=4:
  - Push at 0x00400000..0x0040000C, then a fifth push at 0x00400010.
  - Four pops return 0x00400014, 0x00400010, 0x0040000C, 0x00400008.
  - Fifth pop uses jr_target.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
package pc_pkg;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pcsel_t;

  // Run/halt state.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0040_0180;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack. DEPTH must be a power of two >= 2.
// Push when full overwrites the oldest entry; pop when empty is ignored.
// Push together with pop replaces the current top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             valid
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d, top_idx, wr_idx;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wr_en, pop_eff;

  // ptr_q addresses the next free slot; the top lives just below it.
  assign top_idx = ptr_q - PtrW'(1);
  assign valid   = (cnt_q != '0);
  assign top     = mem_q[top_idx];
  assign pop_eff = pop && valid;

  // Pointer/count next state and write-port selection.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && pop_eff) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntW'(DEPTH)) cnt_d = cnt_q + CntW'(1);
    end else if (pop_eff) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the stack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with internal next-PC selection, run/halt control and
// misaligned-target trapping. Define PC_RAS_EN to add a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
  parameter logic [WIDTH-1:0]  TRAP_VEC  = WIDTH'(TRAP_VEC_DEFAULT),
  parameter int unsigned       INC       = 4,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pcsel,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [25:0]      jaddr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             halt,
  input  logic             resume,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             running,
  output logic             misalign_err,
  output logic [WIDTH-1:0] epc
);

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, cand, ras_top;
  state_t           state_q, state_d;
  logic             err_q, err_d, misalign, ras_hit;

  assign pc           = pc_q;
  assign pc_plus      = pc_q + WIDTH'(INC);
  assign running      = (state_q == RUN);
  assign misalign_err = err_q;
  assign epc          = epc_q;
  assign misalign     = (cand[1:0] != 2'b00);

`ifdef PC_RAS_EN
  logic ras_valid, ras_step;

  // The stack only moves on an enabled, non-trapping RUN cycle.
  assign ras_step = enable && (state_q == RUN) && !misalign;
  assign ras_hit  = ras_pop && ras_valid && (pcsel_t'(pcsel) == PC_REG);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_step && ras_push),
    .pop       (ras_step && ras_pop && (pcsel_t'(pcsel) == PC_REG)),
    .push_data (pc_plus),
    .top       (ras_top),
    .valid     (ras_valid)
  );
`else
  logic unused_ras;

  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ras_push | ras_pop;
`endif

  // Next-PC candidate from the select code.
  always_comb begin
    cand = pc_plus;
    unique case (pcsel_t'(pcsel))
      PC_SEQ:    cand = pc_plus;
      PC_BRANCH: cand = pc_plus + (br_offset << 2);
      PC_JUMP:   cand = {pc_plus[WIDTH-1:28], jaddr, 2'b00};
      PC_REG:    cand = ras_hit ? ras_top : jr_target;
      default:   cand = pc_plus;
    endcase
  end

  // Run/halt next state; a trap outranks a halt request in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    err_d   = err_q;
    if (enable) begin
      case (state_q)
        RUN: begin
          if (misalign) begin
            pc_d  = TRAP_VEC;
            epc_d = cand;
            err_d = 1'b1;
          end else begin
            pc_d = cand;
            if (halt) state_d = HALTED;
          end
        end
        HALTED: begin
          if (resume && !halt) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      state_q <= RUN;
      err_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      err_q   <= err_d;
      epc_q   <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, halt, resume, ras_push, ras_pop;
  logic [1:0]  pcsel;
  logic [31:0] br_offset, jr_target;
  logic [25:0] jaddr;
  logic [31:0] pc, pc_plus, epc;
  logic        running, misalign_err;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pcsel        (pcsel),
    .br_offset    (br_offset),
    .jaddr        (jaddr),
    .jr_target    (jr_target),
    .halt         (halt),
    .resume       (resume),
    .ras_push     (ras_push),
    .ras_pop      (ras_pop),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .running      (running),
    .misalign_err (misalign_err),
    .epc          (epc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; halt = 1'b0; resume = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0; pcsel = 2'b00;
    br_offset = '0; jr_target = '0; jaddr = '0;

    // Reset held two cycles.
    step(); step();
    check_eq("rst_pc", pc, 32'h0040_0000);
    check_eq("rst_run", {31'b0, running}, 32'd1);
    check_eq("rst_err", {31'b0, misalign_err}, 32'd0);
    check_eq("rst_epc", epc, 32'h0);

    // Sequential fetch.
    reset = 1'b1; enable = 1'b1;
    check_eq("seq0", pc, 32'h0040_0000);
    step(); check_eq("seq1", pc, 32'h0040_0004);
    step(); check_eq("seq2", pc, 32'h0040_0008);
    check_eq("pc_plus", pc_plus, 32'h0040_000C);
    step(); step(); check_eq("seq4", pc, 32'h0040_0010);

    // Backward branch then jump.
    pcsel = 2'b01; br_offset = 32'hFFFF_FFFE;
    step(); check_eq("branch", pc, 32'h0040_000C);
    pcsel = 2'b10; jaddr = 26'h0100040;
    step(); check_eq("jump", pc, 32'h0040_0100);

    // Stall ignores halt/resume.
    enable = 1'b0; pcsel = 2'b00; halt = 1'b1; resume = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc", pc, 32'h0040_0100);
      check_eq("stall_run", {31'b0, running}, 32'd1);
    end

    // Misaligned register target with halt in the same cycle.
    enable = 1'b1; resume = 1'b0; pcsel = 2'b11; jr_target = 32'h0040_0102;
    step();
    check_eq("trap_pc", pc, 32'h0040_0180);
    check_eq("trap_epc", epc, 32'h0040_0102);
    check_eq("trap_err", {31'b0, misalign_err}, 32'd1);
    check_eq("trap_run", {31'b0, running}, 32'd1);

    // Move to 0x00400020 and halt there.
    halt = 1'b0; jr_target = 32'h0040_0020;
    step(); check_eq("jr", pc, 32'h0040_0020);
    check_eq("err_sticky", {31'b0, misalign_err}, 32'd1);
    pcsel = 2'b00; halt = 1'b1;
    step();
    check_eq("halt_pc", pc, 32'h0040_0024);
    check_eq("halt_run", {31'b0, running}, 32'd0);
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Halt and resume together keep the core halted.
      if (i == 2) begin halt = 1'b1; resume = 1'b1; end
      else begin halt = 1'b0; resume = 1'b0; end
      step();
      check_eq("held_pc", pc, 32'h0040_0024);
      check_eq("held_run", {31'b0, running}, 32'd0);
    end
    halt = 1'b0; resume = 1'b1;
    step();
    check_eq("resume_run", {31'b0, running}, 32'd1);
    check_eq("resume_pc", pc, 32'h0040_0024);
    resume = 1'b0;
    step(); check_eq("after_resume", pc, 32'h0040_0028);

    // Second trap overwrites epc.
    pcsel = 2'b11; jr_target = 32'h0040_0203;
    step();
    check_eq("trap2_pc", pc, 32'h0040_0180);
    check_eq("trap2_epc", epc, 32'h0040_0203);

    // Halt, then reset while halted with the error flag set.
    pcsel = 2'b00; halt = 1'b1;
    step(); check_eq("halt2_run", {31'b0, running}, 32'd0);
    halt = 1'b0; reset = 1'b0;
    step();
    check_eq("mrst_pc", pc, 32'h0040_0000);
    check_eq("mrst_run", {31'b0, running}, 32'd1);
    check_eq("mrst_err", {31'b0, misalign_err}, 32'd0);
    check_eq("mrst_epc", epc, 32'h0);
    reset = 1'b1;

`ifdef PC_RAS_EN
    // Five pushes into a four-entry stack, then five pops.
    ras_push = 1'b1; pcsel = 2'b00;
    for (int i = 0; i < 5; i++) step();
    check_eq("push_pc", pc, 32'h0040_0014);
    ras_push = 1'b0; ras_pop = 1'b1; pcsel = 2'b11; jr_target = 32'h0040_0800;
    step(); check_eq("pop1", pc, 32'h0040_0014);
    step(); check_eq("pop2", pc, 32'h0040_0010);
    step(); check_eq("pop3", pc, 32'h0040_000C);
    step(); check_eq("pop4", pc, 32'h0040_0008);
    step(); check_eq("pop_empty", pc, 32'h0040_0800);
`else
    // Stack controls have no effect without the stack.
    ras_push = 1'b1; ras_pop = 1'b1; pcsel = 2'b11; jr_target = 32'h0040_0800;
    step(); check_eq("noras1", pc, 32'h0040_0800);
    jr_target = 32'h0040_0900;
    step(); check_eq("noras2", pc, 32'h0040_0900);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
